// File: rtl/sdram_port_arb.sv
// sdram_port_arb -- N-port request arbiter in front of a single SDRAM
// controller port.
//
// Ports:
//   clk, rst_n                    clock, synchronous active-low reset
//   req_valid/req_ready[NPORTS]   per-port handshake (ready is a one-cycle grant)
//   req_we/addr/wdata/wstrb       per-port request fields, port i in slice i
//   rsp_valid[NPORTS], rsp_rdata  one-hot read return, shared data bus
//   mem_valid/we/addr/wdata/wstrb registered downstream request slot
//   mem_ready                     controller accepts the slot
//   mem_rvalid/mem_rdata          in-order read return from the controller
//   err_unexp                     sticky: read return with nothing outstanding
//
// Reads are tracked with an ID FIFO of issuing port indices so that in-order
// returns can be steered back to the right port. Writes are posted and
// untracked.

// Per-port eligibility: a port may be granted when it is valid and, for
// reads, the tracking FIFO still has room.
module sdram_port_arb_lane (
  input  logic en,
  input  logic valid,
  input  logic we,
  input  logic rd_full,
  output logic elig
);
  assign elig = en & valid & (we | ~rd_full);
endmodule

module sdram_port_arb #(
  parameter int NPORTS     = 4,
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int RD_DEPTH   = 4,
  parameter int ARB_MODE   = 0
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic [NPORTS-1:0]              req_valid,
  output logic [NPORTS-1:0]              req_ready,
  input  logic [NPORTS-1:0]              req_we,
  input  logic [NPORTS*ADDR_WIDTH-1:0]   req_addr,
  input  logic [NPORTS*DATA_WIDTH-1:0]   req_wdata,
  input  logic [NPORTS*DATA_WIDTH/8-1:0] req_wstrb,
  output logic [NPORTS-1:0]              rsp_valid,
  output logic [DATA_WIDTH-1:0]          rsp_rdata,
  output logic                           mem_valid,
  output logic                           mem_we,
  output logic [ADDR_WIDTH-1:0]          mem_addr,
  output logic [DATA_WIDTH-1:0]          mem_wdata,
  output logic [DATA_WIDTH/8-1:0]        mem_wstrb,
  input  logic                           mem_ready,
  input  logic                           mem_rvalid,
  input  logic [DATA_WIDTH-1:0]          mem_rdata,
  output logic                           err_unexp
);

  localparam int SW = DATA_WIDTH / 8;
  localparam int IW = $clog2(NPORTS);
  localparam int PW = $clog2(RD_DEPTH);
  localparam int CW = PW + 1;

  logic [IW-1:0]     last_grant;
  logic [IW-1:0]     gnt_idx;
  logic [IW-1:0]     cand;
  logic              gnt_any;
  logic              slot_free;
  logic              do_grant;
  logic              push;
  logic              pop;
  logic              rd_full;
  logic [NPORTS-1:0] elig;

  logic [CW-1:0]     rd_cnt;
  logic [PW-1:0]     wr_ptr;
  logic [PW-1:0]     rd_ptr;
  logic [IW-1:0]     id_fifo [RD_DEPTH];

  // Occupancy is the registered count; a pop this cycle does not open room
  // for a read granted in the same cycle.
  assign rd_full = (rd_cnt == CW'(RD_DEPTH));

  genvar g;
  generate
    for (g = 0; g < NPORTS; g++) begin : g_lane
      sdram_port_arb_lane u_lane (
        .en     (rst_n),
        .valid  (req_valid[g]),
        .we     (req_we[g]),
        .rd_full(rd_full),
        .elig   (elig[g])
      );
    end
  endgenerate

  // Winner selection. Loops run from the lowest-preference candidate to the
  // highest so the last hit is the winner.
  always_comb begin
    gnt_any = 1'b0;
    gnt_idx = '0;
    cand    = '0;
    if (ARB_MODE == 1) begin
      for (int i = NPORTS - 1; i >= 0; i--) begin
        if (elig[i]) begin
          gnt_any = 1'b1;
          gnt_idx = IW'(i);
        end
      end
    end else begin
      // Round-robin: offset 1 from last_grant is most preferred.
      for (int off = NPORTS; off >= 1; off--) begin
        cand = IW'((int'(last_grant) + off) % NPORTS);
        if (elig[cand]) begin
          gnt_any = 1'b1;
          gnt_idx = cand;
        end
      end
    end
  end

  // The slot can take a new request when empty or being consumed this cycle.
  assign slot_free = ~mem_valid | mem_ready;
  assign do_grant  = slot_free & gnt_any;
  assign req_ready = do_grant ? (NPORTS'(1) << gnt_idx) : '0;
  assign push      = do_grant & ~req_we[gnt_idx];
  assign pop       = mem_rvalid & (rd_cnt != '0);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      mem_valid  <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      mem_wstrb  <= '0;
      last_grant <= IW'(NPORTS - 1);
      rd_cnt     <= '0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      rsp_valid  <= '0;
      rsp_rdata  <= '0;
      err_unexp  <= 1'b0;
    end else begin
      // Slot: load on grant, drop valid when consumed with nothing to follow,
      // otherwise hold everything while the controller stalls.
      if (slot_free) begin
        mem_valid <= gnt_any;
        if (gnt_any) begin
          mem_we     <= req_we[gnt_idx];
          mem_addr   <= req_addr[int'(gnt_idx)*ADDR_WIDTH +: ADDR_WIDTH];
          mem_wdata  <= req_wdata[int'(gnt_idx)*DATA_WIDTH +: DATA_WIDTH];
          mem_wstrb  <= req_wstrb[int'(gnt_idx)*SW +: SW];
          last_grant <= gnt_idx;
        end
      end

      // Read tracking; pointers wrap naturally since RD_DEPTH is a power of 2.
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop) begin
        rd_ptr    <= rd_ptr + 1'b1;
        rsp_rdata <= mem_rdata;
      end
      rsp_valid <= pop ? (NPORTS'(1) << id_fifo[rd_ptr]) : '0;

      case ({push, pop})
        2'b10:   rd_cnt <= rd_cnt + 1'b1;
        2'b01:   rd_cnt <= rd_cnt - 1'b1;
        default: rd_cnt <= rd_cnt;
      endcase

      if (mem_rvalid && rd_cnt == '0) err_unexp <= 1'b1;
    end
  end

  // ID storage needs no reset: entries are only read behind a valid count.
  always_ff @(posedge clk) begin
    if (push) id_fifo[wr_ptr] <= gnt_idx;
  end

endmodule

// File: tb/tb_sdram_port_arb.sv
module tb_sdram_port_arb;
  localparam int NP = 4;
  localparam int AW = 32;
  localparam int DW = 32;

  logic            clk = 1'b0;
  logic            rst_n;
  logic [NP-1:0]   req_valid, req_we;
  logic [NP*AW-1:0] req_addr;
  logic [NP*DW-1:0] req_wdata;
  logic [NP*DW/8-1:0] req_wstrb;
  logic            mem_ready, mem_rvalid;
  logic [DW-1:0]   mem_rdata;

  logic [NP-1:0]   req_ready, rsp_valid;
  logic [DW-1:0]   rsp_rdata;
  logic            mem_valid, mem_we, err_unexp;
  logic [AW-1:0]   mem_addr;
  logic [DW-1:0]   mem_wdata;
  logic [DW/8-1:0] mem_wstrb;

  logic [NP-1:0]   fp_req_ready, fp_rsp_valid;
  logic [DW-1:0]   fp_rsp_rdata;
  logic            fp_mem_valid, fp_mem_we, fp_err_unexp;
  logic [AW-1:0]   fp_mem_addr;
  logic [DW-1:0]   fp_mem_wdata;
  logic [DW/8-1:0] fp_mem_wstrb;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  sdram_port_arb #(.NPORTS(NP), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .RD_DEPTH(4), .ARB_MODE(0)) u_rr (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_wstrb(req_wstrb),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .mem_valid(mem_valid), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb), .mem_ready(mem_ready),
    .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata), .err_unexp(err_unexp)
  );

  sdram_port_arb #(.NPORTS(NP), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .RD_DEPTH(4), .ARB_MODE(1)) u_fp (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(fp_req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_wstrb(req_wstrb),
    .rsp_valid(fp_rsp_valid), .rsp_rdata(fp_rsp_rdata), .mem_valid(fp_mem_valid), .mem_we(fp_mem_we),
    .mem_addr(fp_mem_addr), .mem_wdata(fp_mem_wdata), .mem_wstrb(fp_mem_wstrb), .mem_ready(mem_ready),
    .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata), .err_unexp(fp_err_unexp)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    rst_n = 1'b0;
    req_valid = '0; mem_rvalid = 1'b0; mem_ready = 1'b1;
    tick; tick;
    rst_n = 1'b1;
  endtask

  function automatic logic [NP-1:0] oh(input int i);
    logic [NP-1:0] v;
    v = '0;
    v[i] = 1'b1;
    return v;
  endfunction

  initial begin
    rst_n = 1'b0; req_valid = '1; req_we = '0; mem_ready = 1'b1;
    mem_rvalid = 1'b0; mem_rdata = '0; req_wdata = '0; req_wstrb = '1;
    for (int i = 0; i < NP; i++) req_addr[i*AW +: AW] = 32'h100 + i;

    // Reset state
    tick;
    chk("rst_req_ready", req_ready, 0);
    tick;
    chk("rst_mem_valid", mem_valid, 0);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_err", err_unexp, 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_rsp_rdata", rsp_rdata, 0);
    req_valid = '0;
    rst_n = 1'b1;

    // Unexpected read return after reset
    mem_rvalid = 1'b1; mem_rdata = 32'hBAD;
    tick;
    mem_rvalid = 1'b0;
    chk("unexp_err", err_unexp, 1);
    chk("unexp_rsp", rsp_valid, 0);
    do_reset;
    chk("err_cleared", err_unexp, 0);

    // Round-robin 0,1,2,3,0 with one return in cycle 3 to make room
    req_valid = '1; req_we = '0;
    for (int k = 0; k < 5; k++) begin
      mem_rvalid = (k == 3); mem_rdata = 32'hD0;
      #1;
      chk("rr_ready", req_ready, oh(k % 4));
      tick;
      chk("rr_mem_valid", mem_valid, 1);
      chk("rr_mem_addr", mem_addr, 32'h100 + (k % 4));
      if (k == 3) begin
        chk("rr_rsp_valid", rsp_valid, 4'b0001);
        chk("rr_rsp_rdata", rsp_rdata, 32'hD0);
      end
    end
    mem_rvalid = 1'b0;
    req_valid = '0;
    tick;
    chk("idle_mem_valid", mem_valid, 0);
    // Drain ports 1,2,3,0
    for (int j = 0; j < 4; j++) begin
      mem_rvalid = 1'b1; mem_rdata = 32'hE0 + j;
      tick;
      chk("drain_rsp_valid", rsp_valid, oh((j + 1) % 4));
      chk("drain_rsp_rdata", rsp_rdata, 32'hE0 + j);
    end
    mem_rvalid = 1'b0;
    tick;
    chk("drain_done_rsp", rsp_valid, 0);
    chk("drain_done_err", err_unexp, 0);

    // Depth limit: 5th read stalls, a write from another port still goes
    do_reset;
    req_we = 4'b0010;
    req_addr[0*AW +: AW] = 32'h200; req_addr[1*AW +: AW] = 32'h300;
    req_wdata[1*DW +: DW] = 32'hCAFE;
    req_valid = 4'b0001;
    for (int k = 0; k < 4; k++) begin
      #1;
      chk("depth_rd_ready", req_ready, 4'b0001);
      tick;
    end
    req_valid = 4'b0011;
    #1;
    chk("depth_wr_bypass", req_ready, 4'b0010);
    tick;
    chk("depth_mem_we", mem_we, 1);
    chk("depth_mem_addr", mem_addr, 32'h300);
    chk("depth_mem_wdata", mem_wdata, 32'hCAFE);
    req_valid = 4'b0001;
    #1;
    chk("depth_rd_stall", req_ready, 0);
    tick;
    chk("depth_slot_idle", mem_valid, 0);
    mem_rvalid = 1'b1; mem_rdata = 32'h55;
    #1;
    chk("depth_pop_no_free", req_ready, 0);
    tick;
    mem_rvalid = 1'b0;
    chk("depth_pop_rsp", rsp_valid, 4'b0001);
    #1;
    chk("depth_rd_resume", req_ready, 4'b0001);
    tick;

    // Controller backpressure for 3 cycles
    do_reset;
    req_we = '1;
    req_addr[2*AW +: AW] = 32'h400; req_wdata[2*DW +: DW] = 32'h22;
    req_addr[3*AW +: AW] = 32'h500;
    req_valid = 4'b0100;
    #1;
    chk("bp_first_ready", req_ready, 4'b0100);
    tick;
    chk("bp_first_addr", mem_addr, 32'h400);
    mem_ready = 1'b0; req_valid = 4'b1000;
    for (int k = 0; k < 3; k++) begin
      #1;
      chk("bp_no_ready", req_ready, 0);
      tick;
      chk("bp_hold_valid", mem_valid, 1);
      chk("bp_hold_addr", mem_addr, 32'h400);
      chk("bp_hold_wdata", mem_wdata, 32'h22);
      chk("bp_hold_we", mem_we, 1);
    end
    mem_ready = 1'b1;
    #1;
    chk("bp_resume_ready", req_ready, 4'b1000);
    tick;
    chk("bp_resume_addr", mem_addr, 32'h500);
    req_valid = '0;

    // Reads from 2,0,2 routed back in order
    do_reset;
    req_we = '0;
    req_valid = 4'b0100; #1; chk("ord_g0", req_ready, 4'b0100); tick;
    req_valid = 4'b0001; #1; chk("ord_g1", req_ready, 4'b0001); tick;
    req_valid = 4'b0100; #1; chk("ord_g2", req_ready, 4'b0100); tick;
    req_valid = '0;
    mem_rvalid = 1'b1;
    mem_rdata = 32'hD0; tick;
    chk("ord_rsp0", rsp_valid, 4'b0100); chk("ord_dat0", rsp_rdata, 32'hD0);
    mem_rdata = 32'hD1; tick;
    chk("ord_rsp1", rsp_valid, 4'b0001); chk("ord_dat1", rsp_rdata, 32'hD1);
    mem_rdata = 32'hD2; tick;
    chk("ord_rsp2", rsp_valid, 4'b0100); chk("ord_dat2", rsp_rdata, 32'hD2);
    chk("ord_no_err", err_unexp, 0);
    mem_rdata = 32'hD3; tick;
    mem_rvalid = 1'b0;
    chk("ord_extra_rsp", rsp_valid, 0);
    chk("ord_extra_err", err_unexp, 1);

    // Reset mid-transaction discards outstanding read
    do_reset;
    req_valid = 4'b0001; req_we = '0;
    tick;
    req_valid = '0; rst_n = 1'b0;
    tick;
    chk("midrst_mem_valid", mem_valid, 0);
    rst_n = 1'b1; mem_rvalid = 1'b1;
    tick;
    mem_rvalid = 1'b0;
    chk("midrst_err", err_unexp, 1);
    chk("midrst_rsp", rsp_valid, 0);

    // Fixed priority vs round-robin with ports 1 and 3 always valid
    do_reset;
    req_we = '1; req_valid = 4'b1010;
    for (int k = 0; k < 5; k++) begin
      #1;
      chk("fp_ready", fp_req_ready, 4'b0010);
      chk("rr_alt_ready", req_ready, (k % 2) ? 4'b1000 : 4'b0010);
      tick;
    end
    req_valid = '0;
    tick;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
